// File: rtl/fetch_pkg.sv
// Shared codes, window size and fault-state encoding for the fetch stream.
package fetch_pkg;

   localparam logic [3:0] PREFETCH_PF_FAULT  = 4'd14;
   localparam logic [3:0] PREFETCH_GP_FAULT  = 4'd15;
   localparam int         FETCH_WINDOW_BYTES = 8;

   typedef enum logic [1:0] {
      FLT_NONE = 2'd0,
      FLT_GP   = 2'd1,
      FLT_PF   = 2'd2
   } flt_e;

   function automatic logic code_is_data(input logic [3:0] code);
      return (code >= 4'd1) && (code <= 4'd4);
   endfunction

   // Reserved codes fall back to a GP fault.
   function automatic flt_e code_fault(input logic [3:0] code);
      flt_e f;
      case (code)
         PREFETCH_PF_FAULT: f = FLT_PF;
         PREFETCH_GP_FAULT: f = FLT_GP;
         default:           f = FLT_GP;
      endcase
      return f;
   endfunction

   function automatic logic [31:0] len_mask(input logic [3:0] len);
      logic [31:0] m;
      case (len)
         4'd1:    m = 32'h0000_00FF;
         4'd2:    m = 32'h0000_FFFF;
         4'd3:    m = 32'h00FF_FFFF;
         4'd4:    m = 32'hFFFF_FFFF;
         default: m = 32'h0000_0000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/fetch_byte_shifter.sv
// Drops c consumed bytes from the window head and merges up to 4 new bytes
// right after the surviving bytes; bytes above the new count are zeroed.
module fetch_byte_shifter
   import fetch_pkg::*;
(
   input  logic [63:0] win_i,
   input  logic [3:0]  cnt_i,
   input  logic [3:0]  c_i,
   input  logic [31:0] ins_i,
   input  logic [3:0]  ins_len_i,
   output logic [63:0] win_o,
   output logic [3:0]  cnt_o
);

   logic [63:0] shifted_s;
   logic [3:0]  base_s;

   // c_i never exceeds cnt_i, so base_s cannot wrap.
   assign shifted_s = win_i >> {c_i, 3'b000};
   assign base_s    = cnt_i - c_i;
   assign cnt_o     = base_s + ins_len_i;

   // Per-byte select: surviving byte, inserted byte, or zero.
   always_comb begin
      logic [3:0] rel;
      rel   = 4'd0;
      win_o = 64'd0;
      for (int i = 0; i < FETCH_WINDOW_BYTES; i++) begin
         rel = 4'(i) - base_s;
         if (4'(i) < base_s) begin
            win_o[i*8 +: 8] = shifted_s[i*8 +: 8];
         end else if (rel < ins_len_i) begin
            win_o[i*8 +: 8] = ins_i[{rel[1:0], 3'b000} +: 8];
         end else begin
            win_o[i*8 +: 8] = 8'd0;
         end
      end
   end

endmodule

// File: rtl/fetch_stream.sv
// Prefetch FIFO consumer building the decoder's 8-byte instruction window.
// Optional same-cycle bypass of popped bytes: define FETCH_BYPASS_EN.
module fetch_stream
   import fetch_pkg::*;
#(
   parameter int WINDOW_BYTES = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pr_reset,
   input  logic        prefetchfifo_accept_empty,
   input  logic [67:0] prefetchfifo_accept_data,
   output logic        prefetchfifo_accept_do,
   input  logic [3:0]  dec_acceptable,
   output logic [63:0] fetch,
   output logic [3:0]  fetch_valid,
   output logic        fetch_limit,
   output logic        fetch_page_fault
);

   // A pop is allowed only while a full 4-byte entry still fits.
   localparam logic [3:0] POP_MAX_CNT = 4'(WINDOW_BYTES - 4);

   logic [63:0] buf_q, buf_d;
   logic [3:0]  cnt_q, cnt_d;
   flt_e        flt_q, flt_d;
   logic        limit_q, pf_q;

   logic [3:0]  code_s;
   logic        is_data_s;
   logic        pop_s;
   logic [3:0]  len_s;
   logic [63:0] view_win_s;
   logic [3:0]  view_cnt_s;
   logic [3:0]  sh_len_s;
   logic [3:0]  cons_s;
   logic [63:0] nxt_win_s;
   logic [3:0]  nxt_cnt_s;
   logic        unused_s;

   assign code_s    = prefetchfifo_accept_data[67:64];
   assign is_data_s = code_is_data(code_s);
   assign pop_s     = ~rst & ~prefetchfifo_accept_empty & ~pr_reset &
                      (flt_q == FLT_NONE) & (cnt_q <= POP_MAX_CNT);
   assign len_s     = (pop_s & is_data_s) ? code_s : 4'd0;
   assign unused_s  = ^prefetchfifo_accept_data[63:32];

`ifdef FETCH_BYPASS_EN
   // Bytes above cnt_q are kept zero, so OR-merging the new entry is safe.
   assign view_win_s = buf_q |
      ({32'd0, prefetchfifo_accept_data[31:0] & len_mask(len_s)} << {cnt_q, 3'b000});
   assign view_cnt_s = cnt_q + len_s;
   assign sh_len_s   = 4'd0;
`else
   assign view_win_s = buf_q;
   assign view_cnt_s = cnt_q;
   assign sh_len_s   = len_s;
`endif

   assign cons_s = (dec_acceptable > view_cnt_s) ? view_cnt_s : dec_acceptable;

   fetch_byte_shifter u_shifter (
      .win_i     (view_win_s),
      .cnt_i     (view_cnt_s),
      .c_i       (cons_s),
      .ins_i     (prefetchfifo_accept_data[31:0]),
      .ins_len_i (sh_len_s),
      .win_o     (nxt_win_s),
      .cnt_o     (nxt_cnt_s)
   );

   // Next window state, fault latch and flush.
   always_comb begin
      buf_d = nxt_win_s;
      cnt_d = nxt_cnt_s;
      flt_d = flt_q;
      if (pr_reset) begin
         buf_d = 64'd0;
         cnt_d = 4'd0;
         flt_d = FLT_NONE;
      end else if (pop_s && !is_data_s) begin
         flt_d = code_fault(code_s);
      end else begin
         flt_d = flt_q;
      end
   end

   // State registers; fault flags are registered from next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_q   <= 64'd0;
         cnt_q   <= 4'd0;
         flt_q   <= FLT_NONE;
         limit_q <= 1'b0;
         pf_q    <= 1'b0;
      end else begin
         buf_q   <= buf_d;
         cnt_q   <= cnt_d;
         flt_q   <= flt_d;
         limit_q <= (flt_d == FLT_GP) && (cnt_d == 4'd0);
         pf_q    <= (flt_d == FLT_PF) && (cnt_d == 4'd0);
      end
   end

   assign prefetchfifo_accept_do = pop_s;
   assign fetch                  = view_win_s;
   assign fetch_valid            = view_cnt_s;
   assign fetch_limit            = limit_q;
   assign fetch_page_fault       = pf_q;

endmodule

// File: tb/tb_fetch_stream.sv
// Scoreboard bench for fetch_stream: directed steps push expectations, a
// negedge monitor pops and compares them.
module tb_fetch_stream;

   logic        clk = 1'b0;
   logic        rst;
   logic        pr_reset;
   logic        empty;
   logic [67:0] data;
   logic        accept_do;
   logic [3:0]  dec;
   logic [63:0] fetch;
   logic [3:0]  fetch_valid;
   logic        fetch_limit;
   logic        fetch_page_fault;

   always #5 clk = ~clk;

   fetch_stream #(.WINDOW_BYTES(8)) dut (
      .clk                       (clk),
      .rst                       (rst),
      .pr_reset                  (pr_reset),
      .prefetchfifo_accept_empty (empty),
      .prefetchfifo_accept_data  (data),
      .prefetchfifo_accept_do    (accept_do),
      .dec_acceptable            (dec),
      .fetch                     (fetch),
      .fetch_valid               (fetch_valid),
      .fetch_limit               (fetch_limit),
      .fetch_page_fault          (fetch_page_fault)
   );

`ifdef FETCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct {
      int          cyc;
      string       name;
      logic [3:0]  fv;
      logic [63:0] win;
      logic        lim;
      logic        pf;
      logic        ado;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   cyc     = 0;
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic logic [63:0] mask_win(input logic [63:0] w, input logic [3:0] fv);
      logic [63:0] r;
      r = w;
      for (int i = 0; i < 8; i++) begin
         if (i >= int'(fv)) r[i*8 +: 8] = 8'd0;
      end
      return r;
   endfunction

   task automatic chk(input string nm, input string what, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s.%s: got %0h expected %0h", nm, what, act, exp);
      end
   endtask

   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         mon_e = q.pop_front();
         chk(mon_e.name, "fetch_valid", 64'(fetch_valid), 64'(mon_e.fv));
         chk(mon_e.name, "fetch", mask_win(fetch, mon_e.fv), mask_win(mon_e.win, mon_e.fv));
         chk(mon_e.name, "fetch_limit", 64'(fetch_limit), 64'(mon_e.lim));
         chk(mon_e.name, "fetch_page_fault", 64'(fetch_page_fault), 64'(mon_e.pf));
         chk(mon_e.name, "accept_do", 64'(accept_do), 64'(mon_e.ado));
      end
   end

   task automatic push_exp(input string nm, input logic [3:0] fv, input logic [63:0] win,
                           input logic lim, input logic pf, input logic ado);
      exp_t e;
      e.cyc  = cyc;
      e.name = nm;
      e.fv   = fv;
      e.win  = win;
      e.lim  = lim;
      e.pf   = pf;
      e.ado  = ado;
      q.push_back(e);
   endtask

   // One cycle: drive inputs just after the edge, then queue the expectation.
   task automatic step(input string nm, input logic r, input logic emp, input logic [3:0] code,
                       input logic [31:0] dat, input logic [3:0] dc, input logic prr,
                       input logic [3:0] fv, input logic [63:0] win,
                       input logic lim, input logic pf, input logic ado);
      @(posedge clk);
      #1;
      rst      = r;
      empty    = emp;
      data     = {code, 32'd0, dat};
      dec      = dc;
      pr_reset = prr;
      cyc++;
      push_exp(nm, fv, win, lim, pf, ado);
   endtask

   initial begin
      rst      = 1'b1;
      pr_reset = 1'b0;
      empty    = 1'b0;
      data     = {4'd4, 32'd0, 32'h4433_2211};
      dec      = 4'd0;
      push_exp("reset", 4'd0, 64'd0, 1'b0, 1'b0, 1'b0);

      //    name          rst   emp   code   data          dec    prr   fv                         window                                       lim   pf    ado
      step("idle",       1'b0, 1'b1, 4'd0,  32'h0,        4'd0,  1'b0, 4'd0,                      64'd0,                                       1'b0, 1'b0, 1'b0);
      step("pop4",       1'b0, 1'b0, 4'd4,  32'h44332211, 4'd0,  1'b0, BYP ? 4'd4 : 4'd0,         64'h44332211,                                1'b0, 1'b0, 1'b1);
      step("vis4",       1'b0, 1'b1, 4'd0,  32'h0,        4'd0,  1'b0, 4'd4,                      64'h44332211,                                1'b0, 1'b0, 1'b0);
      step("pop2_cons3", 1'b0, 1'b0, 4'd2,  32'h00006655, 4'd3,  1'b0, BYP ? 4'd6 : 4'd4,         BYP ? 64'h665544332211 : 64'h44332211,       1'b0, 1'b0, 1'b1);
      step("win3",       1'b0, 1'b1, 4'd0,  32'h0,        4'd0,  1'b0, 4'd3,                      64'h665544,                                  1'b0, 1'b0, 1'b0);
      step("pop_to5",    1'b0, 1'b0, 4'd2,  32'h00008877, 4'd0,  1'b0, BYP ? 4'd5 : 4'd3,         BYP ? 64'h8877665544 : 64'h665544,           1'b0, 1'b0, 1'b1);
      step("full5_hold", 1'b0, 1'b0, 4'd4,  32'hDDCCBBAA, 4'd1,  1'b0, 4'd5,                      64'h8877665544,                              1'b0, 1'b0, 1'b0);
      step("cnt4_pop",   1'b0, 1'b0, 4'd4,  32'hDDCCBBAA, 4'd0,  1'b0, BYP ? 4'd8 : 4'd4,         BYP ? 64'hDDCCBBAA88776655 : 64'h88776655,   1'b0, 1'b0, 1'b1);
      step("win8_over",  1'b0, 1'b1, 4'd0,  32'h0,        4'd15, 1'b0, 4'd8,                      64'hDDCCBBAA88776655,                        1'b0, 1'b0, 1'b0);
      step("clamped",    1'b0, 1'b1, 4'd0,  32'h0,        4'd0,  1'b0, 4'd0,                      64'd0,                                       1'b0, 1'b0, 1'b0);
      step("pop_bbaa",   1'b0, 1'b0, 4'd2,  32'h0000BBAA, 4'd0,  1'b0, BYP ? 4'd2 : 4'd0,         64'hBBAA,                                    1'b0, 1'b0, 1'b1);
      step("pop_gp",     1'b0, 1'b0, 4'd15, 32'h0,        4'd0,  1'b0, 4'd2,                      64'hBBAA,                                    1'b0, 1'b0, 1'b1);
      step("gp_pend",    1'b0, 1'b0, 4'd4,  32'h11111111, 4'd0,  1'b0, 4'd2,                      64'hBBAA,                                    1'b0, 1'b0, 1'b0);
      step("gp_drain",   1'b0, 1'b0, 4'd4,  32'h11111111, 4'd2,  1'b0, 4'd2,                      64'hBBAA,                                    1'b0, 1'b0, 1'b0);
      step("gp_report",  1'b0, 1'b0, 4'd4,  32'h11111111, 4'd0,  1'b0, 4'd0,                      64'd0,                                       1'b1, 1'b0, 1'b0);
      step("gp_sticky",  1'b0, 1'b0, 4'd4,  32'h11111111, 4'd3,  1'b0, 4'd0,                      64'd0,                                       1'b1, 1'b0, 1'b0);
      step("flush_gp",   1'b0, 1'b1, 4'd0,  32'h0,        4'd0,  1'b1, 4'd0,                      64'd0,                                       1'b1, 1'b0, 1'b0);
      step("pop_after",  1'b0, 1'b0, 4'd4,  32'h04030201, 4'd0,  1'b0, BYP ? 4'd4 : 4'd0,         64'h04030201,                                1'b0, 1'b0, 1'b1);
      step("pop_pf",     1'b0, 1'b0, 4'd14, 32'h0,        4'd0,  1'b0, 4'd4,                      64'h04030201,                                1'b0, 1'b0, 1'b1);
      step("pf_drain",   1'b0, 1'b0, 4'd2,  32'h00000605, 4'd4,  1'b0, 4'd4,                      64'h04030201,                                1'b0, 1'b0, 1'b0);
      step("pf_report",  1'b0, 1'b0, 4'd2,  32'h00000605, 4'd0,  1'b0, 4'd0,                      64'd0,                                       1'b0, 1'b1, 1'b0);
      step("flush_pf",   1'b0, 1'b0, 4'd2,  32'h00000605, 4'd0,  1'b1, 4'd0,                      64'd0,                                       1'b0, 1'b1, 1'b0);
      step("post_flush", 1'b0, 1'b1, 4'd0,  32'h0,        4'd0,  1'b0, 4'd0,                      64'd0,                                       1'b0, 1'b0, 1'b0);
      step("refill4",    1'b0, 1'b0, 4'd4,  32'h04030201, 4'd0,  1'b0, BYP ? 4'd4 : 4'd0,         64'h04030201,                                1'b0, 1'b0, 1'b1);
      step("refill6",    1'b0, 1'b0, 4'd2,  32'h00000605, 4'd0,  1'b0, BYP ? 4'd6 : 4'd4,         BYP ? 64'h060504030201 : 64'h04030201,       1'b0, 1'b0, 1'b1);
      step("flush_cnt6", 1'b0, 1'b0, 4'd2,  32'h00000605, 4'd2,  1'b1, 4'd6,                      64'h060504030201,                            1'b0, 1'b0, 1'b0);
      step("flushed",    1'b0, 1'b1, 4'd0,  32'h0,        4'd0,  1'b0, 4'd0,                      64'd0,                                       1'b0, 1'b0, 1'b0);
      step("pop1",       1'b0, 1'b0, 4'd1,  32'h000000EE, 4'd0,  1'b0, BYP ? 4'd1 : 4'd0,         64'hEE,                                      1'b0, 1'b0, 1'b1);
      step("win1",       1'b0, 1'b1, 4'd0,  32'h0,        4'd0,  1'b0, 4'd1,                      64'hEE,                                      1'b0, 1'b0, 1'b0);
      step("pop_rsvd5",  1'b0, 1'b0, 4'd5,  32'h0,        4'd1,  1'b0, 4'd1,                      64'hEE,                                      1'b0, 1'b0, 1'b1);
      step("rsvd_gp",    1'b0, 1'b0, 4'd4,  32'h11111111, 4'd0,  1'b0, 4'd0,                      64'd0,                                       1'b1, 1'b0, 1'b0);
      step("async_rst",  1'b1, 1'b0, 4'd4,  32'h11111111, 4'd0,  1'b0, 4'd0,                      64'd0,                                       1'b0, 1'b0, 1'b0);

      @(posedge clk);
      @(negedge clk);
      #1;
      n_tests++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
